// File: rtl/ysyx_210544_csru_pkg.sv
// Shared CSR addresses, trap cause codes and trap-sequencer state encoding.
// Optional timer interrupt path is enabled with YSYX_210544_CSR_TIMER_IRQ_EN.
package ysyx_210544_csru_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] MCAUSE_MTIMER  = 64'h8000_0000_0000_0007;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_JUMP = 2'd2,
    ST_RET  = 2'd3
  } csr_state_e;

  // MPP is hardwired to M-mode on read; XS/FS are held 0 so SD is always 0.
  function automatic logic [63:0] mstatus_view(input logic mie, input logic mpie);
    logic [63:0] v;
    v        = 64'h0;
    v[12:11] = 2'b11;
    v[7]     = mpie;
    v[3]     = mie;
    return v;
  endfunction

endpackage

// File: rtl/ysyx_210544_csr_cnt64.sv
// 64-bit free counter with load priority over increment (mcycle/minstret).
// Latency: load or increment visible one cycle after the edge; no backpressure.
// Load value lands exactly; increment resumes on the following cycle.
module ysyx_210544_csr_cnt64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        inc,
  output logic [63:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 64'h0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_210544_csru.sv
// M-mode CSR file and ecall/mret/irq trap sequencer; reads combinational, writes at next edge.
// Holds the pipeline via o_busy while sequencing (2 cycles trap, 1 cycle mret); YSYX_210544_CSR_TIMER_IRQ_EN adds timer irq.
module ysyx_210544_csru
  import ysyx_210544_csru_pkg::*;
#(
  parameter logic [63:0] MTVEC_RST = 64'h0,
  parameter logic [63:0] MHARTID   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_csr_addr,
  input  logic        i_csr_ren,
  input  logic        i_csr_wen,
  input  logic [63:0] i_csr_wdata,
  output logic [63:0] o_csr_rdata,
  input  logic        i_instr_commit,
  input  logic [63:0] i_pc,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic        i_clint_mtip,
  output logic        o_busy,
  output logic        o_pc_jmp,
  output logic [63:0] o_pc_jmpaddr
);

  csr_state_e  state;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [63:0] mie_r;
  logic [63:0] mtvec;
  logic [63:0] mscratch;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [63:0] mip_view;
  logic        irq;
  logic        wr_en;

  assign o_busy = (state != ST_IDLE);
  assign wr_en  = i_csr_wen & (state == ST_IDLE);

`ifdef YSYX_210544_CSR_TIMER_IRQ_EN
  assign irq      = mstatus_mie & mie_r[7] & i_clint_mtip;
  assign mip_view = {56'h0, i_clint_mtip, 7'h0};
`else
  logic unused_mtip;
  assign unused_mtip = i_clint_mtip;
  assign irq         = 1'b0;
  assign mip_view    = 64'h0;
`endif

  ysyx_210544_csr_cnt64 u_mcycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_en && (i_csr_addr == CSR_MCYCLE)),
    .load_val (i_csr_wdata),
    .inc      (1'b1),
    .cnt      (mcycle)
  );

  ysyx_210544_csr_cnt64 u_minstret (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_en && (i_csr_addr == CSR_MINSTRET)),
    .load_val (i_csr_wdata),
    .inc      (i_instr_commit),
    .cnt      (minstret)
  );

  always_comb begin
    o_csr_rdata = 64'h0;
    if (i_csr_ren) begin
      case (i_csr_addr)
        CSR_MSTATUS:  o_csr_rdata = mstatus_view(mstatus_mie, mstatus_mpie);
        CSR_MIE:      o_csr_rdata = mie_r;
        CSR_MTVEC:    o_csr_rdata = mtvec;
        CSR_MSCRATCH: o_csr_rdata = mscratch;
        CSR_MEPC:     o_csr_rdata = mepc;
        CSR_MCAUSE:   o_csr_rdata = mcause;
        CSR_MIP:      o_csr_rdata = mip_view;
        CSR_MCYCLE:   o_csr_rdata = mcycle;
        CSR_MINSTRET: o_csr_rdata = minstret;
        CSR_MHARTID:  o_csr_rdata = MHARTID;
        default:      o_csr_rdata = 64'h0;
      endcase
    end
  end

  // Trap updates are placed after the CSR write so they win on the same registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_r        <= 64'h0;
      mtvec        <= MTVEC_RST;
      mscratch     <= 64'h0;
      mepc         <= 64'h0;
      mcause       <= 64'h0;
      o_pc_jmp     <= 1'b0;
      o_pc_jmpaddr <= 64'h0;
    end else begin
      o_pc_jmp <= 1'b0;
      if (wr_en) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= i_csr_wdata[3];
            mstatus_mpie <= i_csr_wdata[7];
          end
          CSR_MIE:      mie_r    <= i_csr_wdata;
          CSR_MTVEC:    mtvec    <= i_csr_wdata;
          CSR_MSCRATCH: mscratch <= i_csr_wdata;
          CSR_MEPC:     mepc     <= {i_csr_wdata[63:2], 2'b00};
          CSR_MCAUSE:   mcause   <= i_csr_wdata;
          default: ;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (irq || i_ecall) begin
            state        <= ST_TRAP;
            mepc         <= i_pc;
            mcause       <= irq ? MCAUSE_MTIMER : MCAUSE_ECALL_M;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
          end else if (i_mret) begin
            state        <= ST_RET;
            o_pc_jmp     <= 1'b1;
            o_pc_jmpaddr <= mepc;
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
          end
        end
        ST_TRAP: begin
          state        <= ST_JUMP;
          o_pc_jmp     <= 1'b1;
          o_pc_jmpaddr <= {mtvec[63:2], 2'b00};
        end
        ST_JUMP: state <= ST_IDLE;
        ST_RET:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
